// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants, fetch FSM state type and NOP word shared by the fetch/decode stages.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [31:0] NOP     = 32'h0000_0000;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} fetch_state_t;
endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next-PC select (jump over taken branch over sequential).
module pc_next (
  input  logic [31:0] pc,
  input  logic [25:0] target,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);
  logic [31:0] w_plus4;
  logic [31:0] w_boff;
  assign w_plus4 = pc + 32'd4;
  assign w_boff  = {{14{target[15]}}, target[15:0], 2'b00};
  assign next_pc = jump ? {w_plus4[31:28], target, 2'b00} :
                   (branch && zero) ? w_plus4 + w_boff : w_plus4;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing and request/ack instruction fetch feeding decode;
// an instruction is held in instr until execute retires it.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instret
);
  fetch_state_t r_state, w_state_nx;
  logic [31:0] r_pc, r_instr, r_instret, w_next_pc;
  logic        r_req, r_valid, w_capture, w_retire;
  pc_next u_pc_next (
    .pc(r_pc), .target(r_instr[25:0]), .branch(branch), .jump(jump), .zero(zero),
    .next_pc(w_next_pc)
  );
  always_comb begin
    w_capture  = (r_state == S_FETCH) && imem_ack;
    w_retire   = (r_state == S_EXEC) && instr_ready;
    w_state_nx = (r_state == S_IDLE) ? S_FETCH :
                 w_capture ? S_EXEC :
                 w_retire ? S_FETCH : r_state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= NOP;
      r_valid   <= 1'b0;
      r_req     <= 1'b0;
      r_instret <= 32'd0;
    end else begin
      r_state <= w_state_nx;
      r_req   <= (w_state_nx == S_FETCH);
      if (w_capture) begin
        r_instr <= imem_rdata;
        r_valid <= 1'b1;
      end
      if (w_retire) begin
        r_pc      <= w_next_pc;
        r_valid   <= 1'b0;
        r_instret <= r_instret + 32'd1;
      end
    end
  end
  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + 32'd4;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign instret     = r_instret;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven program walk through fetch_unit plus hand-written reset corner cases.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'd0;
  logic [31:0] instr, pc, pc_plus4, instret;
  logic        instr_valid, instr_ready = 1'b0;
  logic        branch = 1'b0, jump = 1'b0, zero = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] npc;
    logic        br;
    logic        jp;
    logic        z;
    int          waits;
    int          hold;
  } vec_t;
  vec_t v[12];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .branch(branch),
    .jump(jump), .zero(zero), .pc(pc), .pc_plus4(pc_plus4), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    v[0]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 3, 2};
    v[1]  = '{32'h0000_0004, 32'h0000_0000, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 0, 0};
    v[2]  = '{32'h0000_0008, 32'h0000_0000, 32'h0000_000C, 1'b0, 1'b0, 1'b1, 0, 0};
    v[3]  = '{32'h0000_000C, 32'h0109_5020, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1, 0};
    v[4]  = '{32'h0000_0010, 32'h1000_FFFE, 32'h0000_000C, 1'b1, 1'b0, 1'b1, 0, 0};
    v[5]  = '{32'h0000_000C, 32'h1000_FFFE, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 0, 1};
    v[6]  = '{32'h0000_0010, 32'h1000_FFFB, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0, 0};
    v[7]  = '{32'h0000_0000, 32'h1000_FFFE, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 0, 0};
    v[8]  = '{32'hFFFF_FFFC, 32'h8C08_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0};
    v[9]  = '{32'h0000_0000, 32'h1000_FFFD, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b1, 0, 0};
    v[10] = '{32'hFFFF_FFF8, 32'h0800_0040, 32'hF000_0100, 1'b1, 1'b1, 1'b1, 0, 0};
    v[11] = '{32'hF000_0100, 32'h0BFF_FFFF, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 2, 1};

    imem_ack = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    tick;
    tick;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instret", instret, 32'd0);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 12; i++) begin
      chk("req_on", {31'd0, imem_req}, 32'd1);
      chk("req_addr", imem_addr, v[i].pc);
      for (int w = 0; w < v[i].waits; w++) begin
        imem_ack = 1'b0;
        instr_ready = 1'b1;
        imem_rdata = 32'hBAD0_0000 + w;
        tick;
        chk("wait_addr", imem_addr, v[i].pc);
        chk("wait_req", {31'd0, imem_req}, 32'd1);
        chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      end
      instr_ready = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = v[i].rdata;
      tick;
      chk("cap_instr", instr, v[i].rdata);
      chk("cap_valid", {31'd0, instr_valid}, 32'd1);
      chk("cap_req", {31'd0, imem_req}, 32'd0);
      chk("pc_plus4", pc_plus4, v[i].pc + 32'd4);
      for (int h = 0; h < v[i].hold; h++) begin
        imem_ack = 1'b1;
        imem_rdata = ~v[i].rdata;
        branch = 1'b1;
        jump = 1'b1;
        zero = 1'b1;
        tick;
        chk("hold_instr", instr, v[i].rdata);
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_pc", pc, v[i].pc);
      end
      imem_ack = 1'b0;
      instr_ready = 1'b1;
      branch = v[i].br;
      jump = v[i].jp;
      zero = v[i].z;
      tick;
      instr_ready = 1'b0;
      branch = 1'b0;
      jump = 1'b0;
      zero = 1'b0;
      chk("next_addr", imem_addr, v[i].npc);
      chk("ret_valid", {31'd0, instr_valid}, 32'd0);
      chk("ret_instret", instret, i + 1);
    end

    // Reset while an instruction waits in execute: it must not retire.
    imem_ack = 1'b1;
    imem_rdata = 32'h2008_1234;
    tick;
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    rst_n = 1'b0;
    instr_ready = 1'b1;
    branch = 1'b1;
    zero = 1'b1;
    tick;
    chk("rstx_valid", {31'd0, instr_valid}, 32'd0);
    chk("rstx_instret", instret, 32'd0);
    chk("rstx_instr", instr, 32'd0);
    chk("rstx_pc", pc, 32'd0);
    rst_n = 1'b1;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    branch = 1'b0;
    zero = 1'b0;
    tick;
    chk("rstx_req", {31'd0, imem_req}, 32'd1);
    chk("rstx_addr", imem_addr, 32'd0);

    // Reset during an outstanding fetch, then a late ack while idle.
    tick;
    rst_n = 1'b0;
    tick;
    chk("rstf_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick;
    chk("late_instr", instr, 32'd0);
    chk("late_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_req", {31'd0, imem_req}, 32'd1);
    chk("late_addr", imem_addr, 32'd0);
    imem_ack = 1'b0;
    tick;
    chk("late_still", {31'd0, instr_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and PC sequencing stage directly upstream of the main decoder. Holds the program counter, issues a request/acknowledge read to instruction memory, and presents the fetched word (and thus the opcode field) to decode. When the execute side retires the instruction, it selects the next PC from the decoder's Branch/Jump controls and the ALU zero flag.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  instruction memory read request, registered.
- imem_addr  out  32  read address; equals pc.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- instr  out  32  current instruction register; instr[31:26] feeds decoder opcode.
- instr_valid  out  1  instr holds an unretired instruction.
- instr_ready  in  1  execute retires the current instruction this cycle.
- branch  in  1  decoder Branch for current instr.
- jump  in  1  decoder Jump for current instr.
- zero  in  1  ALU zero flag for current instr.
- pc  out  32  address of current/pending instruction.
- pc_plus4  out  32  pc + 4, combinational.
- instret  out  32  retired-instruction counter.

## Operation
- States: S_IDLE, S_FETCH, S_EXEC.
- Reset (rst_n=0 at edge): state=S_IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, instret=0.
- S_IDLE: imem_req=0; unconditionally -> S_FETCH.
- S_FETCH: imem_req=1, imem_addr=pc held stable until ack. On imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, -> S_EXEC. Otherwise stay.
- S_EXEC: instr_valid=1, imem_req=0. On instr_ready=1: pc<=next_pc, instr_valid<=0, instret<=instret+1, -> S_FETCH. Otherwise hold all.
- next_pc priority: jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch & zero -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
- branch, jump, zero sampled only in the cycle S_EXEC & instr_ready=1; ignored otherwise.
- All PC arithmetic modulo 2^32: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000; negative offsets wrap likewise.
- instret wraps 32'hFFFF_FFFF -> 0.
- imem_ack outside S_FETCH ignored (no state or instr change).
- instr_ready outside S_EXEC ignored.

## Timing
- Zero-wait memory (ack same cycle as req): release reset at edge 0 -> S_IDLE; edge 1 -> S_FETCH, req=1; edge 2 captures instr, instr_valid=1; instr_ready in that cycle -> edge 3 new pc, req=1. Throughput: one instruction per 2 cycles minimum.
- N wait cycles on ack add N cycles; imem_addr constant throughout.
- Reset mid-fetch: req drops at the reset edge; a late ack after reset (in S_IDLE) is discarded; first post-reset request is to RESET_PC.
- Reset in S_EXEC: instr_valid=0 at the reset edge; instruction not retired, instret=0.
- Reset has priority over every simultaneous event.

## Structure
- Shared package mips_pkg: opcode constants (R-type 6'b000000, LW 6'b100011, SW 6'b101011, BEQ 6'b000100, ADDI 6'b001000, J 6'b000010), fetch_state_t enum, NOP word 32'h0000_0000.
- Sub-module pc_next: combinational next-PC mux (pc, instr, branch, jump, zero -> next_pc); top holds FSM, registers, counter.

## Test plan
- Reset + zero-wait sequential: RESET_PC=0, ack each req, ready immediately -> imem_addr 0x0, 0x4, 0x8 on req cycles; instret=3 after third retire.
- Wait states + hold: ack delayed 3 cycles, then ready held low 2 cycles -> imem_addr stable at 0x0 for 4 req cycles; instr/instr_valid stable until ready.
- Branch: pc=0x10, instr=BEQ offset 16'hFFFE, branch=1, zero=1 -> next pc 0x0C; same with zero=0 -> 0x14.
- Jump priority: pc=0x8000_0010, instr J target 26'h000_0040, jump=1, branch=1, zero=1 -> next pc 0x8000_0100.
- Wrap: pc=0xFFFF_FFFC sequential retire -> next request address 0x0000_0000.
- Reset mid-fetch: assert rst_n=0 during outstanding req, ack arrives while in S_IDLE -> instr=0, instr_valid=0, next req to RESET_PC.
